// File: rtl/cmp_unit_pipe_if.sv
// Handshake bundle for cmp_unit_pipe: operand/decode request in, compare result out.
// master = producer side (execute issue + result consumer), slave = the compare unit.
interface cmp_unit_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [6:0]      opcode;
  logic [2:0]      func3;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            branch_taken;
  logic            illegal;

  modport master (
    output in_valid, op1, op2, opcode, func3, out_ready,
    input  in_ready, out_valid, result, branch_taken, illegal
  );

  modport slave (
    input  in_valid, op1, op2, opcode, func3, out_ready,
    output in_ready, out_valid, result, branch_taken, illegal
  );
endinterface

// File: rtl/cmp_unit_pipe.sv
// SLT-family and branch-condition compare unit; CMP_UNIT_PERF_EN adds delivered/taken counters.
// Latency: op accepted in cycle N is presented in cycle N+LATENCY; 1 op/cycle when unstalled.
// Backpressure: a stalled output holds; each stage refills in the same cycle it drains, in_ready falls when full.
module cmp_unit_pipe #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  cmp_unit_pipe_if.slave    cmp
`ifdef CMP_UNIT_PERF_EN
  ,
  output logic [31:0]       perf_ops,
  output logic [31:0]       perf_taken
`endif
);

  localparam int LAST = LATENCY - 1;

  localparam logic [6:0] OPC_REG = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;

  // SLT results are only ever 0/1, so the pipe carries a single result bit.
  typedef struct packed {
    logic res;
    logic tkn;
    logic ill;
  } pay_t;

  logic eq, lt_s, lt_u;
  pay_t dec;

  assign eq   = (cmp.op1 == cmp.op2);
  assign lt_u = (cmp.op1 < cmp.op2);
  assign lt_s = ($signed(cmp.op1) < $signed(cmp.op2));

  always_comb begin
    dec     = '0;
    dec.ill = 1'b1;
    case (cmp.opcode)
      OPC_REG, OPC_IMM: begin
        case (cmp.func3)
          3'b010: begin dec.res = lt_s; dec.ill = 1'b0; end
          3'b011: begin dec.res = lt_u; dec.ill = 1'b0; end
          default: ;
        endcase
      end
      OPC_BR: begin
        dec.ill = 1'b0;
        case (cmp.func3)
          3'b000:  dec.tkn = eq;
          3'b001:  dec.tkn = !eq;
          3'b100:  dec.tkn = lt_s;
          3'b101:  dec.tkn = !lt_s;
          3'b110:  dec.tkn = lt_u;
          3'b111:  dec.tkn = !lt_u;
          default: dec.ill = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  logic [LATENCY-1:0] vld;
  logic [LATENCY-1:0] src_vld;
  logic [LATENCY:0]   adv;
  pay_t               pay     [LATENCY];
  pay_t               src_pay [LATENCY];

  // adv[k]: stage k may load this cycle; adv[LATENCY] is the downstream accept.
  always_comb begin
    adv[LATENCY] = cmp.out_ready;
    for (int k = LATENCY - 1; k >= 0; k--) begin
      adv[k] = !vld[k] || adv[k+1];
    end
  end

  always_comb begin
    src_vld[0] = cmp.in_valid;
    src_pay[0] = dec;
    for (int k = 1; k < LATENCY; k++) begin
      src_vld[k] = vld[k-1];
      src_pay[k] = pay[k-1];
    end
  end

  // Payload is only written when a valid op moves in, so idle stages do not toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        pay[k] <= '0;
      end
    end else begin
      for (int k = 0; k < LATENCY; k++) begin
        if (adv[k]) begin
          vld[k] <= src_vld[k];
          if (src_vld[k]) begin
            pay[k] <= src_pay[k];
          end
        end
      end
    end
  end

  assign cmp.in_ready     = adv[0];
  assign cmp.out_valid    = vld[LAST];
  assign cmp.result       = {{(XLEN-1){1'b0}}, pay[LAST].res};
  assign cmp.branch_taken = pay[LAST].tkn;
  assign cmp.illegal      = pay[LAST].ill;

`ifdef CMP_UNIT_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops   <= '0;
      perf_taken <= '0;
    end else if (vld[LAST] && cmp.out_ready) begin
      perf_ops <= perf_ops + 32'd1;
      if (pay[LAST].tkn) begin
        perf_taken <= perf_taken + 32'd1;
      end
    end
  end
`else
  // Counter-free build: nothing beyond the compare pipe.
`endif

endmodule

// File: tb/tb_cmp_unit_pipe.sv
// Scoreboard bench for cmp_unit_pipe: directed decode/latency/stall/reset cases plus a random stream.
module tb_cmp_unit_pipe;
  localparam int XLEN    = 32;
  localparam int LATENCY = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cmp_unit_pipe_if #(.XLEN(XLEN)) bus ();

`ifdef CMP_UNIT_PERF_EN
  logic [31:0] perf_ops;
  logic [31:0] perf_taken;
`endif

  cmp_unit_pipe #(.XLEN(XLEN), .LATENCY(LATENCY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cmp   (bus)
`ifdef CMP_UNIT_PERF_EN
    ,
    .perf_ops   (perf_ops),
    .perf_taken (perf_taken)
`endif
  );

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic            tkn;
    logic            ill;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_miss = 0;
  int   n_dlv = 0;
  bit   rnd_done = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t ex(input logic r, input logic t, input logic i);
    exp_t e;
    e.res = {31'b0, r};
    e.tkn = t;
    e.ill = i;
    return e;
  endfunction

  // Reference decode; signed order via sign-bit flip then unsigned compare.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [6:0] opc, input logic [2:0] f3);
    exp_t e;
    logic lts, ltu, eqv;
    lts = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    ltu = a < b;
    eqv = a == b;
    e = ex(1'b0, 1'b0, 1'b1);
    if ((opc == 7'h33 || opc == 7'h13) && (f3 == 3'b010 || f3 == 3'b011)) begin
      e.ill = 1'b0;
      e.res = {31'b0, (f3 == 3'b010) ? lts : ltu};
    end else if (opc == 7'h63 && f3 != 3'b010 && f3 != 3'b011) begin
      e.ill = 1'b0;
      case (f3)
        3'b000:  e.tkn = eqv;
        3'b001:  e.tkn = !eqv;
        3'b100:  e.tkn = lts;
        3'b101:  e.tkn = !lts;
        3'b110:  e.tkn = ltu;
        default: e.tkn = !ltu;
      endcase
    end
    return e;
  endfunction

  // Output monitor: pops on delivery, and while stalled requires the head result to be presented.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_out", bus.out_valid, 1'b0);
      end else if (bus.out_ready) begin
        mon_e = sb.pop_front();
        check("payload", {bus.result, bus.branch_taken, bus.illegal}, mon_e);
        n_dlv++;
      end else begin
        check("hold", {bus.result, bus.branch_taken, bus.illegal}, sb[0]);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [6:0] opc, input logic [2:0] f3, input exp_t e);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.op1      = a;
    bus.op2      = b;
    bus.opcode   = opc;
    bus.func3    = f3;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", bus.in_ready, 1'b1);
  endtask

  task automatic send_m(input logic [31:0] a, input logic [31:0] b,
                        input logic [6:0] opc, input logic [2:0] f3);
    send(a, b, opc, f3, model(a, b, opc, f3));
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && sb.size() != 0; t++) @(posedge clk);
    @(posedge clk);
    #1;
    check("drain_left", sb.size(), 0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin : main
    int base;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op1       = '0;
    bus.op2       = '0;
    bus.opcode    = '0;
    bus.func3     = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_result", bus.result, 32'd0);
    check("rst_taken", bus.branch_taken, 1'b0);
    check("rst_illegal", bus.illegal, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // SLT with exact latency observation
    send(32'hFFFF_FFFF, 32'h0000_0001, 7'h33, 3'b010, ex(1'b1, 1'b0, 1'b0));
    idle();
    for (int i = 1; i < LATENCY; i++) begin
      @(negedge clk);
      check("lat_early", bus.out_valid, 1'b0);
    end
    @(negedge clk);
    check("lat_due", bus.out_valid, 1'b1);
    @(posedge clk);
    #1;
    send(32'hFFFF_FFFF, 32'h0000_0001, 7'h33, 3'b011, ex(1'b0, 1'b0, 1'b0));
    send(32'hFFFF_FFFE, 32'hFFFF_FFFF, 7'h13, 3'b010, ex(1'b1, 1'b0, 1'b0));
    send(32'h0000_0005, 32'h0000_0005, 7'h13, 3'b011, ex(1'b0, 1'b0, 1'b0));

    // Branch sweep on equal operands at the sign boundary
    send(32'h8000_0000, 32'h8000_0000, 7'h63, 3'b000, ex(1'b0, 1'b1, 1'b0));
    send(32'h8000_0000, 32'h8000_0000, 7'h63, 3'b001, ex(1'b0, 1'b0, 1'b0));
    send(32'h8000_0000, 32'h8000_0000, 7'h63, 3'b100, ex(1'b0, 1'b0, 1'b0));
    send(32'h8000_0000, 32'h8000_0000, 7'h63, 3'b101, ex(1'b0, 1'b1, 1'b0));
    send(32'h8000_0000, 32'h8000_0000, 7'h63, 3'b110, ex(1'b0, 1'b0, 1'b0));
    send(32'h8000_0000, 32'h8000_0000, 7'h63, 3'b111, ex(1'b0, 1'b1, 1'b0));
    send(32'h7FFF_FFFF, 32'h8000_0000, 7'h63, 3'b100, ex(1'b0, 1'b0, 1'b0));
    send(32'h7FFF_FFFF, 32'h8000_0000, 7'h63, 3'b110, ex(1'b0, 1'b1, 1'b0));
    send(32'h7FFF_FFFF, 32'h8000_0000, 7'h63, 3'b101, ex(1'b0, 1'b1, 1'b0));
    send(32'h7FFF_FFFF, 32'h8000_0000, 7'h63, 3'b001, ex(1'b0, 1'b1, 1'b0));

    // Illegal decodes, with operands that would otherwise set result/taken
    send(32'h0000_0001, 32'h0000_0002, 7'h37, 3'b010, ex(1'b0, 1'b0, 1'b1));
    send(32'h0000_0001, 32'h0000_0002, 7'h37, 3'b000, ex(1'b0, 1'b0, 1'b1));
    send(32'h0000_0001, 32'h0000_0002, 7'h63, 3'b010, ex(1'b0, 1'b0, 1'b1));
    send(32'h0000_0003, 32'h0000_0003, 7'h63, 3'b011, ex(1'b0, 1'b0, 1'b1));
    send(32'h0000_0001, 32'h0000_0002, 7'h33, 3'b000, ex(1'b0, 1'b0, 1'b1));
    idle();
    drain();

    // Back-to-back stream with a downstream stall
    base = n_dlv;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send_m(32'(i) * 32'h3000_0001, 32'h5000_0000,
                 (i % 2 == 0) ? 7'h63 : 7'h33, 3'(i + 2));
        end
        idle();
      end
      begin
        repeat (2) @(posedge clk);
        #2 bus.out_ready = 1'b0;
        repeat (8) @(negedge clk);
        check("bp_in_ready", bus.in_ready, 1'b0);
        check("bp_inflight", sb.size(), LATENCY);
        @(posedge clk);
        #2 bus.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_delivered", n_dlv - base, 6);

    // Reset with ops held in the pipe
    bus.out_ready = 1'b0;
    send_m(32'h0000_0001, 32'h0000_0009, 7'h33, 3'b010);
    send_m(32'h0000_0004, 32'h0000_0004, 7'h63, 3'b000);
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_vld", bus.out_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_vld", bus.out_valid, 1'b0);
    check("rst_async_rdy", bus.in_ready, 1'b1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_stale", bus.out_valid, 1'b0);
    end
    check("rst_rel_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;

`ifdef CMP_UNIT_PERF_EN
    check("perf_ops_rst", perf_ops, 32'd0);
    send_m(32'h0000_0007, 32'h0000_0007, 7'h63, 3'b000);
    send_m(32'h0000_0007, 32'h0000_0008, 7'h63, 3'b001);
    send_m(32'h0000_0001, 32'h0000_0002, 7'h63, 3'b110);
    send_m(32'h0000_0001, 32'h0000_0002, 7'h33, 3'b010);
    send_m(32'h0000_0009, 32'h0000_0002, 7'h63, 3'b110);
    idle();
    drain();
    check("perf_ops", perf_ops, 32'd5);
    check("perf_taken", perf_taken, 32'd3);
    force dut.perf_ops = 32'hFFFF_FFFF;
    #1 release dut.perf_ops;
    send_m(32'h0000_0003, 32'h0000_0003, 7'h63, 3'b000);
    idle();
    drain();
    check("perf_ops_wrap", perf_ops, 32'd0);
    check("perf_taken_after", perf_taken, 32'd4);
`endif

    // Random stream with random downstream stalls
    base = n_dlv;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          logic [31:0] a, b;
          logic [6:0]  opc;
          a = pick_operand();
          b = ($urandom_range(0, 3) == 0) ? a : pick_operand();
          case ($urandom_range(0, 4))
            0:       opc = 7'h33;
            1:       opc = 7'h13;
            2, 3:    opc = 7'h63;
            default: opc = 7'($urandom);
          endcase
          send_m(a, b, opc, 3'($urandom));
          if ($urandom_range(0, 4) == 0) begin
            idle();
            @(posedge clk);
            #1;
          end
        end
        idle();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #2 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("rnd_delivered", n_dlv - base, 150);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
